gmii_rgmii_tx: RTL and testbench

// - Ethernet transmit path: accepts payload bytes on a valid/ready/last stream, builds a complete frame
//   (preamble, SFD, payload, optional pad, FCS), enforces inter-frame gap, drives RGMII TX pins via ODDR.
// - Sits between the MAC/packet source and the PHY; transmit-side counterpart of the RGMII->GMII receive path.

---
 rtl/gmii_rgmii_tx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_gmii_rgmii_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rgmii_tx.sv
// gmii_rgmii_tx: Ethernet transmit framer with an RGMII DDR pin stage.
// A payload byte stream comes in on valid/ready/last. The block wraps it with a
// preamble, an SFD and an FCS, and enforces the inter-frame gap. It then drives
// the RGMII TX pins through an output DDR stage that models an ODDR with an
// asynchronous reset.
// Optional feature: define GMII_TX_PAD_EN to zero-pad short frames up to
// MIN_FRAME bytes before the FCS. With the macro undefined the PAD state is
// unreachable and the FCS follows the last payload byte directly.
`timescale 1ns/1ps
module gmii_rgmii_tx #(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned PRE_BYTES = 7,
    parameter int unsigned MIN_FRAME = 60
) (
    input  logic       gmii_txc,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_err,
    output logic       s_ready,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun,
    output logic       rgmii_txc,
    output logic       rgmii_tx_ctl,
    output logic [3:0] rgmii_td
);

`ifdef GMII_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SFD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAD   = 3'd4,
        ST_FCS   = 3'd5,
        ST_DRAIN = 3'd6,
        ST_IFG   = 3'd7
    } state_t;

    // One byte step of the reflected CRC-32 (polynomial 0xEDB88320).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_r, state_next;
    logic [3:0]  pre_cnt_r, pre_cnt_next;
    logic [7:0]  ifg_cnt_r, ifg_cnt_next;
    logic [1:0]  fcs_idx_r, fcs_idx_next;
    logic [10:0] byte_cnt_r, byte_cnt_next;
    logic [10:0] byte_inc_s;
    logic [31:0] crc_r, crc_next;
    logic [31:0] crc_inv_s;
    logic [7:0]  fcs_byte_s;

    // GMII-side registered outputs (one cycle ahead of the pins)
    logic [7:0]  txd_r, txd_next;
    logic        tx_en_r, tx_en_next;
    logic        tx_er_r, tx_er_next;
    logic        done_r, done_next;
    logic        underrun_r, underrun_next;
    logic        s_ready_r;
    logic        tx_busy_r;

    // DDR pin stage: rising-edge and falling-edge halves captured together
    logic        ctl_rise_r, ctl_fall_r;
    logic [3:0]  td_rise_r, td_fall_r;
    logic        txc_rise_r;

    // The byte counter only feeds the pad decision, so it saturates rather than wraps.
    assign byte_inc_s = (byte_cnt_r == 11'h7FF) ? byte_cnt_r : (byte_cnt_r + 11'd1);
    assign crc_inv_s  = ~crc_r;

    // Select the FCS byte for the current FCS cycle, least significant byte first.
    always_comb begin
        case (fcs_idx_r)
            2'd0:    fcs_byte_s = crc_inv_s[7:0];
            2'd1:    fcs_byte_s = crc_inv_s[15:8];
            2'd2:    fcs_byte_s = crc_inv_s[23:16];
            2'd3:    fcs_byte_s = crc_inv_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Frame FSM: next state, counters, CRC and the next GMII byte.
    always_comb begin
        state_next    = state_r;
        pre_cnt_next  = 4'd0;
        ifg_cnt_next  = 8'd0;
        fcs_idx_next  = 2'd0;
        byte_cnt_next = byte_cnt_r;
        crc_next      = crc_r;
        txd_next      = 8'h00;
        tx_en_next    = 1'b0;
        tx_er_next    = 1'b0;
        done_next     = 1'b0;
        underrun_next = 1'b0;
        case (state_r)
            ST_IDLE: begin
                byte_cnt_next = 11'd0;
                crc_next      = CRC_INIT;
                if (s_valid) begin
                    state_next = ST_PRE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_PRE: begin
                txd_next   = 8'h55;
                tx_en_next = 1'b1;
                if (pre_cnt_r == 4'(PRE_BYTES - 1)) begin
                    state_next = ST_SFD;
                end else begin
                    pre_cnt_next = pre_cnt_r + 4'd1;
                end
            end
            ST_SFD: begin
                txd_next      = 8'hD5;
                tx_en_next    = 1'b1;
                byte_cnt_next = 11'd0;
                crc_next      = CRC_INIT;
                state_next    = ST_DATA;
            end
            ST_DATA: begin
                tx_en_next = 1'b1;
                if (s_valid) begin
                    txd_next      = s_data;
                    tx_er_next    = s_err;
                    crc_next      = crc32_byte(crc_r, s_data);
                    byte_cnt_next = byte_inc_s;
                    if (s_last) begin
                        if (PAD_ON && (byte_inc_s < 11'(MIN_FRAME))) begin
                            state_next = ST_PAD;
                        end else begin
                            state_next = ST_FCS;
                        end
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    // Source starved mid-payload: poison the frame and drop the rest.
                    txd_next      = 8'h00;
                    tx_er_next    = 1'b1;
                    underrun_next = 1'b1;
                    state_next    = ST_DRAIN;
                end
            end
            ST_PAD: begin
                txd_next      = 8'h00;
                tx_en_next    = 1'b1;
                crc_next      = crc32_byte(crc_r, 8'h00);
                byte_cnt_next = byte_inc_s;
                if (byte_inc_s < 11'(MIN_FRAME)) begin
                    state_next = ST_PAD;
                end else begin
                    state_next = ST_FCS;
                end
            end
            ST_FCS: begin
                txd_next   = fcs_byte_s;
                tx_en_next = 1'b1;
                if (fcs_idx_r == 2'd3) begin
                    done_next  = 1'b1;
                    state_next = ST_IFG;
                end else begin
                    fcs_idx_next = fcs_idx_r + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    done_next  = 1'b1;
                    state_next = ST_IFG;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_IFG: begin
                // A waiting source goes straight to preamble, so the gap is exactly IFG_BYTES.
                if (ifg_cnt_r == 8'(IFG_BYTES - 1)) begin
                    if (s_valid) begin
                        state_next = ST_PRE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    ifg_cnt_next = ifg_cnt_r + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters, CRC, GMII byte and status outputs.
    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pre_cnt_r  <= 4'd0;
            ifg_cnt_r  <= 8'd0;
            fcs_idx_r  <= 2'd0;
            byte_cnt_r <= 11'd0;
            crc_r      <= CRC_INIT;
            txd_r      <= 8'h00;
            tx_en_r    <= 1'b0;
            tx_er_r    <= 1'b0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
            s_ready_r  <= 1'b0;
            tx_busy_r  <= 1'b0;
        end else begin
            state_r    <= state_next;
            pre_cnt_r  <= pre_cnt_next;
            ifg_cnt_r  <= ifg_cnt_next;
            fcs_idx_r  <= fcs_idx_next;
            byte_cnt_r <= byte_cnt_next;
            crc_r      <= crc_next;
            txd_r      <= txd_next;
            tx_en_r    <= tx_en_next;
            tx_er_r    <= tx_er_next;
            done_r     <= done_next;
            underrun_r <= underrun_next;
            s_ready_r  <= (state_next == ST_DATA) || (state_next == ST_DRAIN);
            tx_busy_r  <= (state_next != ST_IDLE);
        end
    end

    // DDR output stage: capture both halves on the rising edge, clear asynchronously.
    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            ctl_rise_r <= 1'b0;
            ctl_fall_r <= 1'b0;
            td_rise_r  <= 4'h0;
            td_fall_r  <= 4'h0;
            txc_rise_r <= 1'b0;
        end else begin
            ctl_rise_r <= tx_en_r;
            ctl_fall_r <= tx_en_r ^ tx_er_r;
            td_rise_r  <= txd_r[3:0];
            td_fall_r  <= txd_r[7:4];
            txc_rise_r <= 1'b1;
        end
    end

    // High clock phase carries the rising-edge half, low phase the falling-edge half.
    assign rgmii_tx_ctl = gmii_txc ? ctl_rise_r : ctl_fall_r;
    assign rgmii_td     = gmii_txc ? td_rise_r  : td_fall_r;
    assign rgmii_txc    = gmii_txc & txc_rise_r;

    assign s_ready    = s_ready_r;
    assign tx_busy    = tx_busy_r;
    assign frame_done = done_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_gmii_rgmii_tx.sv
// Self-checking bench for gmii_rgmii_tx. The pins are decoded back into
// {tx_en, tx_er, byte} per cycle and compared against frames built from a
// byte-level reference model that uses a table-driven CRC-32. The bench
// follows GMII_TX_PAD_EN so that pad expectations match the build.
`timescale 1ns/1ps
module tb_gmii_rgmii_tx;
    localparam int IFG  = 12;
    localparam int PRE  = 7;
    localparam int MINF = 60;
`ifdef GMII_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       gmii_txc = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_err;
    logic       s_ready, tx_busy, frame_done, underrun;
    logic       rgmii_txc, rgmii_tx_ctl;
    logic [3:0] rgmii_td;

    gmii_rgmii_tx #(.IFG_BYTES(IFG), .PRE_BYTES(PRE), .MIN_FRAME(MINF)) dut (
        .gmii_txc(gmii_txc), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_err(s_err),
        .s_ready(s_ready), .tx_busy(tx_busy), .frame_done(frame_done), .underrun(underrun),
        .rgmii_txc(rgmii_txc), .rgmii_tx_ctl(rgmii_tx_ctl), .rgmii_td(rgmii_td)
    );

    always #4 gmii_txc = ~gmii_txc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge gmii_txc) cyc <= cyc + 1;

    // Monitor state
    logic [9:0]  got_q[$];
    logic [9:0]  exp_q[$];
    int          gaps_q[$];
    int          segs, fd_cnt, ur_cnt, first_en_cyc, zero_run;
    bit          in_seg;
    logic [7:0]  pl_q[$];
    logic [31:0] crc_tab[256];

    typedef struct {
        int len;
        bit incr;
        int err_idx;
        int exp_len;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        gaps_q.delete();
        segs = 0; fd_cnt = 0; ur_cnt = 0; first_en_cyc = -1; zero_run = 0; in_seg = 1'b0;
    endtask

    // Decode the pins once per clock: rise half at posedge+1, fall half at negedge+1.
    always begin : mon
        logic       r_ctl, f_ctl, fd, ur;
        logic [3:0] r_td, f_td;
        int         stamp;
        @(posedge gmii_txc); #1;
        r_ctl = rgmii_tx_ctl; r_td = rgmii_td; fd = frame_done; ur = underrun; stamp = cyc;
        @(negedge gmii_txc); #1;
        f_ctl = rgmii_tx_ctl; f_td = rgmii_td;
        if (fd) fd_cnt++;
        if (ur) ur_cnt++;
        if (r_ctl) begin
            if (!in_seg) begin
                segs++;
                if (segs > 1) gaps_q.push_back(zero_run);
                if (first_en_cyc < 0) first_en_cyc = stamp;
            end
            in_seg = 1'b1;
            got_q.push_back({r_ctl, r_ctl ^ f_ctl, f_td, r_td});
        end else begin
            if (in_seg) zero_run = 0;
            in_seg = 1'b0;
            zero_run++;
        end
    end

    task automatic make_pl(input int len, input bit incr, input int base);
        pl_q.delete();
        for (int i = 0; i < len; i++) begin
            if (incr) pl_q.push_back(8'(base + i));
            else      pl_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic add_pre();
        for (int i = 0; i < PRE; i++) exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b10, 8'hD5});
    endtask

    // Reference frame: preamble, SFD, payload (+pad), ~CRC LSB first.
    task automatic add_exp(input int err_idx);
        logic [7:0]  body[$];
        logic [31:0] c;
        add_pre();
        body = pl_q;
        if (PAD) while (body.size() < MINF) body.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < body.size(); i++) begin
            exp_q.push_back({1'b1, (i == err_idx), body[i]});
            c = (c >> 8) ^ crc_tab[c[7:0] ^ body[i]];
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({2'b10, c[8*k +: 8]});
    endtask

    task automatic send(input int err_idx, input int stall_at, input int abort_at, input bit keep_valid);
        int t;
        bit acc;
        for (int i = 0; i < pl_q.size(); i++) begin
            if (i == stall_at) begin
                s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
                repeat (3) begin @(posedge gmii_txc); #1; end
            end
            if (i == 0) start_cyc = cyc;
            s_valid = 1'b1; s_data = pl_q[i];
            s_last = (i == pl_q.size() - 1); s_err = (i == err_idx);
            if (i == abort_at) return;
            acc = 1'b0; t = 0;
            while (!acc) begin
                @(negedge gmii_txc); acc = s_ready;
                @(posedge gmii_txc); #1;
                t++;
                if (!acc && t > 400) begin
                    checks++; errors++;
                    $display("FAIL accept_timeout: byte %0d got s_ready=0 required 1", i);
                    s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
                    return;
                end
            end
        end
        if (!keep_valid) begin s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge gmii_txc);
        while (tx_busy === 1'b1 && t < 4000) begin @(negedge gmii_txc); t++; end
        check("idle_reached", tx_busy, 32'd0);
        repeat (4) @(negedge gmii_txc);
        @(posedge gmii_txc); #1;
    endtask

    task automatic cmp_stream(input string name);
        int bad = -1;
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data: at byte %0d got {en,er,d}=%03h required %03h",
                     name, bad, got_q[bad], exp_q[bad]);
        end
    endtask

    initial begin
        int len, err, kvi, n;
        bit kv_q[$];

        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = 32'(i);
            for (int b = 0; b < 8; b++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
            crc_tab[i] = v;
        end

        tbl[0] = '{64,  1'b1, -1, 76};
        tbl[1] = '{14,  1'b1, -1, PAD ? 72 : 26};
        tbl[2] = '{1,   1'b0, -1, PAD ? 72 : 13};
        tbl[3] = '{60,  1'b0,  5, 72};
        tbl[4] = '{100, 1'b0, 99, 112};
        tbl[5] = '{59,  1'b0, -1, PAD ? 72 : 71};
        tbl[6] = '{61,  1'b0, -1, 73};

        // Reset state
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_err = 1'b0;
        clear_mon();
        #2;
        check("rst_ctl_low", rgmii_tx_ctl, 32'd0);
        check("rst_td_low", rgmii_td, 32'd0);
        #3;
        check("rst_txc_held", rgmii_txc, 32'd0);
        check("rst_ctl_high", rgmii_tx_ctl, 32'd0);
        check("rst_status", {s_ready, tx_busy, frame_done, underrun}, 32'd0);
        @(negedge gmii_txc); @(negedge gmii_txc);
        rst_n = 1'b1;
        @(posedge gmii_txc); #1;
        check("txc_fwd_high", rgmii_txc, 32'd1);
        @(negedge gmii_txc); #1;
        check("txc_fwd_low", rgmii_txc, 32'd0);
        @(posedge gmii_txc); #1;

        // Table-driven single frames
        for (int v = 0; v < 7; v++) begin
            clear_mon(); exp_q.delete();
            make_pl(tbl[v].len, tbl[v].incr, 0);
            add_exp(tbl[v].err_idx);
            send(tbl[v].err_idx, -1, -1, 1'b0);
            wait_idle();
            check($sformatf("tbl%0d_wire_len", v), got_q.size(), tbl[v].exp_len);
            cmp_stream($sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_latency", v), first_en_cyc - start_cyc, 32'd3);
            check($sformatf("tbl%0d_segs", v), segs, 32'd1);
            check($sformatf("tbl%0d_done", v), fd_cnt, 32'd1);
            check($sformatf("tbl%0d_underrun", v), ur_cnt, 32'd0);
        end

        // Back-to-back frames with s_valid held high
        clear_mon(); exp_q.delete();
        make_pl(30, 1'b1, 8'h40); add_exp(-1); send(-1, -1, -1, 1'b1);
        make_pl(20, 1'b0, 0);     add_exp(-1); send(-1, -1, -1, 1'b0);
        wait_idle();
        cmp_stream("b2b");
        check("b2b_segs", segs, 32'd2);
        check("b2b_done", fd_cnt, 32'd2);
        check("b2b_gap_count", gaps_q.size(), 32'd1);
        if (gaps_q.size() > 0) check("b2b_gap", gaps_q[0], IFG);

        // Underrun after byte 20, rest of frame drained
        clear_mon(); exp_q.delete();
        make_pl(25, 1'b1, 8'h80);
        add_pre();
        for (int i = 0; i < 20; i++) exp_q.push_back({2'b10, pl_q[i]});
        exp_q.push_back({2'b11, 8'h00});
        send(-1, 20, -1, 1'b0);
        wait_idle();
        cmp_stream("underrun");
        check("underrun_pulse", ur_cnt, 32'd1);
        check("underrun_done", fd_cnt, 32'd1);
        check("underrun_segs", segs, 32'd1);

        // Reset asserted while byte 30 of the payload is offered
        make_pl(64, 1'b1, 0);
        send(-1, -1, 30, 1'b0);
        #1;
        check("live_before_rst", rgmii_tx_ctl, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", rgmii_tx_ctl, 32'd0);
        check("midrst_td", rgmii_td, 32'd0);
        check("midrst_txc", rgmii_txc, 32'd0);
        s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
        repeat (3) @(posedge gmii_txc);
        @(negedge gmii_txc); rst_n = 1'b1;
        @(posedge gmii_txc); #1;
        clear_mon();
        repeat (20) begin @(posedge gmii_txc); #1; end
        check("postrst_quiet", segs, 32'd0);
        check("postrst_busy", tx_busy, 32'd0);
        exp_q.delete();
        make_pl(20, 1'b0, 0); add_exp(-1);
        send(-1, -1, -1, 1'b0);
        wait_idle();
        cmp_stream("postrst");
        check("postrst_latency", first_en_cyc - start_cyc, 32'd3);

        // Randomized frames against the reference model
        clear_mon(); exp_q.delete(); kv_q.delete();
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 90);
            err = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            kvi = (f < 5) ? int'($urandom_range(0, 1)) : 0;
            make_pl(len, 1'b0, 0);
            add_exp(err);
            kv_q.push_back(kvi != 0);
            send(err, -1, -1, kvi != 0);
            if (kvi == 0) begin
                n = $urandom_range(1, 15);
                repeat (n) begin @(posedge gmii_txc); #1; end
            end
        end
        wait_idle();
        cmp_stream("rand");
        check("rand_segs", segs, 32'd6);
        check("rand_done", fd_cnt, 32'd6);
        check("rand_underrun", ur_cnt, 32'd0);
        check("rand_gap_count", gaps_q.size(), 32'd5);
        for (int g = 0; g < gaps_q.size() && g < 5; g++) begin
            if (kv_q[g]) check($sformatf("rand_gap%0d_exact", g), gaps_q[g], IFG);
            else         check($sformatf("rand_gap%0d_min", g), gaps_q[g] >= IFG, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
